shot_scheduler: RTL and testbench

//  Arbitrates fire requests from NREQ shooters (player ship, enemy saucers) onto the shared shot pool.

---
 rtl/shot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_shot_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shot_scheduler.sv
// rtl/shot_scheduler.sv - round-robin fire arbiter, pool slot allocator and delete queue for the shot pool
// Optional build macro SHOT_SCHED_STATS_EN adds spawn_count/drop_count outputs.
module shot_scheduler #(
  parameter int SHOT_COUNT = 10,
  parameter int SLOT_W     = 4,
  parameter int NREQ       = 4,
  parameter int COOLDOWN   = 8,
  parameter int DEL_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [6*NREQ-1:0]     req_dir,
  input  logic [10*NREQ-1:0]    req_x,
  input  logic [10*NREQ-1:0]    req_y,
  input  logic [SHOT_COUNT-1:0] slot_valid,
  input  logic                  del_req,
  input  logic [SLOT_W-1:0]     del_addr,
  output logic                  del_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  spawn_valid,
  output logic [SLOT_W-1:0]     spawn_slot,
  output logic [2:0]            spawn_entity,
  output logic [5:0]            spawn_dir,
  output logic [9:0]            spawn_x,
  output logic [9:0]            spawn_y,
  output logic                  spawn_drop,
  output logic                  delete_valid,
  output logic [SLOT_W-1:0]     delete_addr
`ifdef SHOT_SCHED_STATS_EN
  ,
  output logic [15:0]           spawn_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int PTR_W = (DEL_DEPTH > 1) ? $clog2(DEL_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]            rr_ptr;
  logic [7:0]            cool [NREQ];
  logic [SHOT_COUNT-1:0] reserved;
  logic [SLOT_W-1:0]     fifo_mem [DEL_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic                  any_elig, any_free, do_spawn, do_drop, do_push, do_pop, pop_ok;
  logic [2:0]            winner;
  logic [SLOT_W-1:0]     free_slot, pop_addr;
  logic [SHOT_COUNT-1:0] reserved_next;
  logic [CNT_W-1:0]      fifo_cnt_next;
  int                    idx;

  always_comb begin
    any_elig  = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_elig && req[idx] && cool[idx] == 8'd0) begin
        any_elig = 1'b1;
        winner   = 3'(idx);
      end
    end
    // descending scan so the lowest free index is the one left standing
    any_free  = 1'b0;
    free_slot = '0;
    for (int s = SHOT_COUNT - 1; s >= 0; s--) begin
      if (!slot_valid[s] && !reserved[s]) begin
        any_free  = 1'b1;
        free_slot = SLOT_W'(s);
      end
    end
  end

  assign do_spawn      = any_elig && any_free;
  assign do_drop       = any_elig && !any_free;
  assign do_push       = del_req && del_ready;
  assign do_pop        = (fifo_cnt != '0);
  assign pop_addr      = fifo_mem[rd_ptr];
  assign pop_ok        = do_pop && (int'(pop_addr) < SHOT_COUNT);
  assign fifo_cnt_next = fifo_cnt + CNT_W'(do_push) - CNT_W'(do_pop);

  always_comb begin
    reserved_next = reserved & ~slot_valid;
    if (pop_ok)
      reserved_next[pop_addr] = 1'b0;
    if (do_spawn)
      reserved_next[free_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      fifo_mem[wr_ptr] <= del_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      reserved     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      del_ready    <= 1'b1;
      grant        <= '0;
      spawn_valid  <= 1'b0;
      spawn_slot   <= '0;
      spawn_entity <= '0;
      spawn_dir    <= '0;
      spawn_x      <= '0;
      spawn_y      <= '0;
      spawn_drop   <= 1'b0;
      delete_valid <= 1'b0;
      delete_addr  <= '0;
      for (int i = 0; i < NREQ; i++)
        cool[i] <= 8'd0;
`ifdef SHOT_SCHED_STATS_EN
      spawn_count  <= '0;
      drop_count   <= '0;
`endif
    end else begin
      grant       <= do_spawn ? (NREQ'(1) << winner) : '0;
      spawn_valid <= do_spawn;
      spawn_drop  <= do_drop;
      if (do_spawn) begin
        spawn_slot   <= free_slot;
        spawn_entity <= winner;
        spawn_dir    <= req_dir[6*winner +: 6];
        spawn_x      <= req_x[10*winner +: 10];
        spawn_y      <= req_y[10*winner +: 10];
        rr_ptr       <= (int'(winner) == NREQ - 1) ? 3'd0 : winner + 3'd1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (do_spawn && int'(winner) == i)
          cool[i] <= 8'(COOLDOWN);
        else if (cool[i] != 8'd0)
          cool[i] <= cool[i] - 8'd1;
      end
      reserved <= reserved_next;

      // out-of-range entries are still popped, just never issued
      delete_valid <= pop_ok;
      if (pop_ok)
        delete_addr <= pop_addr;
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt  <= fifo_cnt_next;
      del_ready <= (fifo_cnt_next != CNT_W'(DEL_DEPTH));
`ifdef SHOT_SCHED_STATS_EN
      if (do_spawn)
        spawn_count <= spawn_count + 16'd1;
      if (do_drop)
        drop_count <= drop_count + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// tb/tb_shot_scheduler.sv - randomized and directed checks of shot_scheduler against a behavioural model
module tb_shot_scheduler;
  localparam int SC = 10, SW = 4, NR = 4, CD = 8, DD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [6*NR-1:0]  req_dir = '0;
  logic [10*NR-1:0] req_x = '0, req_y = '0;
  logic [SC-1:0] slot_valid = '0;
  logic          del_req = 1'b0;
  logic [SW-1:0] del_addr = '0;
  logic          del_ready, spawn_valid, spawn_drop, delete_valid;
  logic [NR-1:0] grant;
  logic [SW-1:0] spawn_slot, delete_addr;
  logic [2:0]    spawn_entity;
  logic [5:0]    spawn_dir;
  logic [9:0]    spawn_x, spawn_y;

  shot_scheduler #(.SHOT_COUNT(SC), .SLOT_W(SW), .NREQ(NR), .COOLDOWN(CD), .DEL_DEPTH(DD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_dir(req_dir), .req_x(req_x), .req_y(req_y),
    .slot_valid(slot_valid), .del_req(del_req), .del_addr(del_addr), .del_ready(del_ready),
    .grant(grant), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_entity(spawn_entity),
    .spawn_dir(spawn_dir), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_drop(spawn_drop),
    .delete_valid(delete_valid), .delete_addr(delete_addr));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state: grant history per shooter, search start, reserved slots, delete queue
  int last_g [NR];
  int rr, cyc;
  bit res [SC];
  int dq [$];
  int e_grant, e_slot, e_ent, e_dir, e_x, e_y, e_da;
  bit e_sv, e_drop, e_dv, e_ready;
  int del_seen [$];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) last_g[i] = -1000;
    for (int s = 0; s < SC; s++) res[s] = 0;
    rr = 0; cyc = 0; dq.delete();
    e_grant = 0; e_sv = 0; e_drop = 0; e_dv = 0; e_ready = 1;
    e_slot = 0; e_ent = 0; e_dir = 0; e_x = 0; e_y = 0; e_da = 0;
  endfunction

  function automatic void model_step();
    int w = -1, fs = -1, a;
    bit push;
    for (int k = 0; k < NR; k++) begin
      int i = (rr + k) % NR;
      // counter loaded at the grant decision, reaches zero COOLDOWN+1 cycles later
      if (w < 0 && req[i] && (cyc - last_g[i]) > CD) w = i;
    end
    for (int s = 0; s < SC; s++)
      if (fs < 0 && !slot_valid[s] && !res[s]) fs = s;
    e_grant = 0; e_sv = 0; e_drop = 0; e_dv = 0;
    if (w >= 0 && fs >= 0) begin
      e_sv = 1; e_grant = 1 << w; e_slot = fs; e_ent = w;
      e_dir = int'(req_dir[6*w +: 6]); e_x = int'(req_x[10*w +: 10]); e_y = int'(req_y[10*w +: 10]);
      last_g[w] = cyc; rr = (w + 1) % NR;
    end else if (w >= 0) begin
      e_drop = 1;
    end
    push = del_req && e_ready;
    if (dq.size() > 0) begin
      a = dq.pop_front();
      if (a < SC) begin e_dv = 1; e_da = a; end
    end
    for (int s = 0; s < SC; s++) if (slot_valid[s]) res[s] = 0;
    if (e_dv) res[e_da] = 0;
    if (e_sv) res[fs] = 1;
    if (push) dq.push_back(int'(del_addr));
    e_ready = (dq.size() != DD);
    cyc++;
  endfunction

  task automatic compare_all();
    check("grant", 32'(grant), 32'(e_grant));
    check("spawn_valid", 32'(spawn_valid), 32'(e_sv));
    check("spawn_drop", 32'(spawn_drop), 32'(e_drop));
    check("delete_valid", 32'(delete_valid), 32'(e_dv));
    check("del_ready", 32'(del_ready), 32'(e_ready));
    if (e_sv) begin
      check("spawn_slot", 32'(spawn_slot), 32'(e_slot));
      check("spawn_entity", 32'(spawn_entity), 32'(e_ent));
      check("spawn_dir", 32'(spawn_dir), 32'(e_dir));
      check("spawn_x", 32'(spawn_x), 32'(e_x));
      check("spawn_y", 32'(spawn_y), 32'(e_y));
    end
    if (e_dv) check("delete_addr", 32'(delete_addr), 32'(e_da));
    if (delete_valid) del_seen.push_back(int'(delete_addr));
  endtask

  // inputs are set just after a falling edge; outputs checked at the next falling edge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_spawn_valid"}, 32'(spawn_valid), 32'd0);
    check({tag, "_spawn_drop"}, 32'(spawn_drop), 32'd0);
    check({tag, "_delete_valid"}, 32'(delete_valid), 32'd0);
    check({tag, "_del_ready"}, 32'(del_ready), 32'd1);
    check({tag, "_spawn_slot"}, 32'(spawn_slot), 32'd0);
  endtask

  task automatic reset_dut();
    req = '0; del_req = 1'b0; slot_valid = '0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // single shooter spawn
    req = 4'b0001; req_dir[5:0] = 6'h05; req_x[9:0] = 10'd16; req_y[9:0] = 10'd31;
    tick();
    check("t1_valid", 32'(spawn_valid), 32'd1);
    check("t1_slot", 32'(spawn_slot), 32'd0);
    check("t1_grant", 32'(grant), 32'd1);
    req = '0;
    tick();

    // all shooters: round robin over consecutive cycles, then cooldown holds them off
    reset_dut();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_grant", 32'(grant), 32'(1 << k));
      check("t2_slot", 32'(spawn_slot), 32'(k));
    end
    for (int k = 4; k < 9; k++) begin
      tick();
      check("t2_cool", 32'(grant), 32'd0);
    end
    repeat (4) tick();

    // full pool: drops only, then a freed slot is used
    reset_dut();
    slot_valid = 10'h3FF; req = 4'b0001;
    repeat (5) begin
      tick();
      check("t3_drop", 32'(spawn_drop), 32'd1);
      check("t3_grant", 32'(grant), 32'd0);
    end
    slot_valid[7] = 1'b0;
    tick();
    check("t3_slot7", 32'(spawn_slot), 32'd7);
    req = '0;
    tick();

    // delete burst, then an out-of-range address that must vanish
    reset_dut();
    del_seen.delete();
    for (int a = 1; a <= 5; a++) begin
      del_addr = SW'(a); del_req = 1'b1;
      tick();
    end
    del_addr = 4'd12;
    tick();
    del_addr = 4'd6;
    tick();
    del_req = 1'b0;
    repeat (4) tick();
    check("t4_count", 32'(del_seen.size()), 32'd6);
    for (int i = 0; i < 6 && i < del_seen.size(); i++)
      check("t4_order", 32'(del_seen[i]), 32'(i + 1));

    // asynchronous reset while a spawn is on the outputs
    reset_dut();
    req = 4'b0100;
    tick();
    req = 4'b0010;
    model_step();
    @(posedge clk);
    #2;
    check("t5_pending", 32'(spawn_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    model_reset();
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1111;
    tick();
    check("t5_first", 32'(grant), 32'd1);

    // randomized traffic
    reset_dut();
    for (int n = 0; n < 2500; n++) begin
      req        = NR'($urandom);
      req_dir    = 24'($urandom);
      req_x      = 40'({$urandom, $urandom});
      req_y      = 40'({$urandom, $urandom});
      slot_valid = ($urandom_range(0, 7) == 0) ? 10'h3FF : (10'($urandom) & 10'($urandom));
      del_req    = ($urandom_range(0, 2) != 0);
      del_addr   = SW'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
